// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI slave.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT,
        FRAME_END
    } state_e;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    // Frame carries two command bits ahead of the payload.
    function automatic int unsigned frame_w(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins plus rx/tx handshakes and error pulses of the SPI slave.
interface spi_slave_param_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned FRAME_W = spi_pkg::frame_w(DATA_W);

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               frame_err;
    logic               overrun;

    modport slave (
        input  SS_n, MOSI, rx_ready, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, tx_ready, frame_err, overrun
    );

    modport master (
        output SS_n, MOSI, rx_ready, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, tx_ready, frame_err, overrun
    );

endinterface

// File: rtl/spi_tx_serializer.sv
// MSB-first read-data serializer; MISO is registered and idles at 0.
module spi_tx_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              busy,
    output logic              done
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  left_q;
    logic              busy_q;
    logic              miso_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_q <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else if (load) begin
            // MSB goes out immediately; the remaining bits queue up behind it.
            miso_q  <= data[DATA_W-1];
            shift_q <= data << 1;
            left_q  <= CNT_W'(DATA_W - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (left_q == '0) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                miso_q  <= shift_q[DATA_W-1];
                shift_q <= shift_q << 1;
                left_q  <= left_q - 1'b1;
            end
        end
    end

    assign miso = miso_q;
    assign busy = busy_q;
    assign done = busy_q && (left_q == '0);

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave: frame deserialiser, rx/tx handshakes, read timeout and error pulses.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_slave_param_if.slave  bus
);
    localparam int unsigned FRAME_W = frame_w(DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned TMO_W   = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_W);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TX_TIMEOUT);

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               addr_seen_q;
    logic               frame_err_q;
    logic               overrun_q;

    logic tx_accept;
    logic ser_clear;
    logic ser_busy;
    logic ser_done;

    // Abort has priority over a same-cycle tx_valid.
    assign tx_accept = (state_q == TX_WAIT) && !bus.SS_n && bus.tx_valid && !ser_busy;
    assign ser_clear = (state_q == TX_SHIFT) && bus.SS_n;

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_accept),
        .clear (ser_clear),
        .data  (bus.tx_data),
        .miso  (bus.MISO),
        .busy  (ser_busy),
        .done  (ser_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addr_seen_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (!bus.SS_n) begin
                        state_q <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    if (bus.SS_n) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else begin
                        bit_cnt_q <= CNT_LOAD;
                        shift_q   <= '0;
                        if (!bus.MOSI) begin
                            state_q <= WRITE;
                        end else if (addr_seen_q) begin
                            state_q <= READ_DATA;
                        end else begin
                            state_q <= READ_ADD;
                        end
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q == '0) begin
                        // Frame complete: this wins over a simultaneous SS_n release.
                        if (rx_valid_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end
                        if (state_q == READ_ADD) begin
                            addr_seen_q <= 1'b1;
                        end
                        if (bus.SS_n) begin
                            state_q <= IDLE;
                        end else if (state_q == READ_DATA) begin
                            state_q   <= TX_WAIT;
                            tmo_cnt_q <= '0;
                        end else begin
                            state_q <= FRAME_END;
                        end
                    end else if (bus.SS_n) begin
                        state_q     <= IDLE;
                        shift_q     <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        shift_q   <= {shift_q[FRAME_W-2:0], bus.MOSI};
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end

                TX_WAIT: begin
                    if (bus.SS_n) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (tx_accept) begin
                        addr_seen_q <= 1'b0;
                        state_q     <= TX_SHIFT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        if (tmo_cnt_q == TMO_LIMIT - 1'b1) begin
                            state_q     <= FRAME_END;
                            frame_err_q <= 1'b1;
                        end
                    end
                end

                TX_SHIFT: begin
                    if (bus.SS_n) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (ser_done) begin
                        state_q <= FRAME_END;
                    end
                end

                FRAME_END: begin
                    if (bus.SS_n) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_ready  = tx_accept;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: directed frames, queued expectations, negedge monitor.
module tb_spi_slave_param;
    import spi_pkg::*;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned TX_TIMEOUT = 16;

    typedef struct {
        int         cyc;
        logic [9:0] frame;
    } rx_exp_t;

    typedef struct {
        int   cyc;
        logic bit_v;
    } miso_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    rx_exp_t   q_rx[$];
    miso_exp_t q_miso[$];
    int        q_ferr[$];
    int        q_ovr[$];
    int        q_txr[$];

    rx_exp_t   mon_rx;
    miso_exp_t mon_m;
    int        mon_e;

    spi_slave_param_if #(.DATA_W(DATA_W)) bus ();

    spi_slave_param #(
        .DATA_W     (DATA_W),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got a pulse, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input int c, input logic [9:0] f);
        rx_exp_t e;
        e.cyc   = c;
        e.frame = f;
        q_rx.push_back(e);
    endtask

    task automatic push_miso(input int c, input logic b);
        miso_exp_t e;
        e.cyc   = c;
        e.bit_v = b;
        q_miso.push_back(e);
    endtask

    // e0 is the edge at which IDLE samples SS_n low; returns after nbits frame bits shifted.
    task automatic start_frame(input logic dir, input logic [9:0] frame, input int nbits,
                               output int e0);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        tick();
        e0 = cyc;
        bus.MOSI = dir;
        tick();
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = frame[9-i];
            tick();
        end
        bus.MOSI = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (q_rx.size() == 0) begin
                    unexpected("rx_valid");
                end else begin
                    mon_rx = q_rx.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(mon_rx.frame));
                    if (mon_rx.cyc >= 0) chk("rx_valid_cycle", cyc, mon_rx.cyc);
                end
            end
            if (bus.frame_err) begin
                if (q_ferr.size() == 0) unexpected("frame_err");
                else begin
                    mon_e = q_ferr.pop_front();
                    chk("frame_err_cycle", cyc, mon_e);
                end
            end
            if (bus.overrun) begin
                if (q_ovr.size() == 0) unexpected("overrun");
                else begin
                    mon_e = q_ovr.pop_front();
                    chk("overrun_cycle", cyc, mon_e);
                end
            end
            if (bus.tx_ready) begin
                if (q_txr.size() == 0) unexpected("tx_ready");
                else begin
                    mon_e = q_txr.pop_front();
                    chk("tx_ready_cycle", cyc, mon_e);
                end
            end
            if (q_miso.size() != 0 && q_miso[0].cyc == cyc) begin
                mon_m = q_miso.pop_front();
                chk("miso_bit", 32'(bus.MISO), 32'(mon_m.bit_v));
            end else begin
                chk("miso_idle", 32'(bus.MISO), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        logic [7:0] rd;

        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.rx_ready = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (2) tick();
        chk("reset_miso", 32'(bus.MISO), 0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 0);
        chk("reset_rx_data", 32'(bus.rx_data), 0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // Reset after four frame bits of a write.
        start_frame(1'b0, 10'h3FF, 4, e0);
        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        tick();
        chk("midreset_miso", 32'(bus.MISO), 0);
        chk("midreset_rx_valid", 32'(bus.rx_valid), 0);
        chk("midreset_rx_data", 32'(bus.rx_data), 0);
        chk("midreset_tx_ready", 32'(bus.tx_ready), 0);
        chk("midreset_frame_err", 32'(bus.frame_err), 0);
        chk("midreset_overrun", 32'(bus.overrun), 0);
        chk("midreset_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        repeat (2) tick();

        // Plain write frame.
        start_frame(1'b0, 10'h0A5, 10, e0);
        push_rx(e0 + 12, 10'h0A5);
        repeat (2) tick();
        bus.SS_n = 1'b1;
        tick();

        // Read address, then read data with tx_valid after three wait cycles.
        start_frame(1'b1, 10'h233, 10, e0);
        push_rx(e0 + 12, 10'h233);
        tick();
        bus.SS_n = 1'b1;
        tick();
        start_frame(1'b1, 10'h35A, 10, e0);
        push_rx(e0 + 12, 10'h35A);
        repeat (4) tick();
        rd = 8'hC3;
        q_txr.push_back(e0 + 15);
        for (int i = 0; i < 8; i++) push_miso(e0 + 16 + i, rd[7-i]);
        bus.tx_valid = 1'b1;
        bus.tx_data  = rd;
        tick();
        bus.tx_valid = 1'b0;
        repeat (9) tick();
        chk("addr_seen_cleared", 32'(dut.addr_seen_q), 0);
        chk("tx_done_state", 32'(dut.state_q), 32'(FRAME_END));
        bus.SS_n = 1'b1;
        tick();

        // Read data with no tx_valid: timeout.
        start_frame(1'b1, 10'h2F0, 10, e0);
        push_rx(e0 + 12, 10'h2F0);
        tick();
        bus.SS_n = 1'b1;
        tick();
        start_frame(1'b1, 10'h3AA, 10, e0);
        push_rx(e0 + 12, 10'h3AA);
        q_ferr.push_back(e0 + 28);
        repeat (17) tick();
        chk("addr_seen_kept", 32'(dut.addr_seen_q), 1);
        chk("timeout_state", 32'(dut.state_q), 32'(FRAME_END));
        bus.SS_n = 1'b1;
        tick();

        // Two writes with rx_ready low: second one overruns.
        bus.rx_ready = 1'b0;
        start_frame(1'b0, 10'h012, 10, e0);
        push_rx(-1, 10'h012);
        tick();
        bus.SS_n = 1'b1;
        tick();
        start_frame(1'b0, 10'h1F0, 10, e0);
        q_ovr.push_back(e0 + 12);
        tick();
        bus.SS_n = 1'b1;
        tick();
        chk("overrun_rx_valid", 32'(bus.rx_valid), 1);
        chk("overrun_rx_held", 32'(bus.rx_data), 32'h012);
        bus.rx_ready = 1'b1;
        repeat (2) tick();

        // SS_n released after the command bits and five payload bits.
        start_frame(1'b0, 10'h155, 7, e0);
        bus.SS_n = 1'b1;
        q_ferr.push_back(e0 + 9);
        tick();
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        chk("abort_rx_valid", 32'(bus.rx_valid), 0);
        repeat (3) tick();

        chk("rx_queue_drained", q_rx.size(), 0);
        chk("frame_err_queue_drained", q_ferr.size(), 0);
        chk("overrun_queue_drained", q_ovr.size(), 0);
        chk("tx_ready_queue_drained", q_txr.size(), 0);
        chk("miso_queue_drained", q_miso.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised next-generation SPI slave for the SPI/RAM subsystem. MOSI and SS_n are sampled synchronously on clk.
- Deserialises command frames of 2 command bits plus DATA_W payload bits.
- Delivers each frame to the memory side over a valid/ready handshake.
- Serialises read data back on MISO.
- Adds, relative to the previous slave: a back-pressured rx handshake, a tx_ready handshake, a read-wait timeout, and frame-abort and overrun error reporting.

Parameters:
DATA_W, 8, payload width in bits; frame width FRAME_W = DATA_W+2.
TX_TIMEOUT, 16, cycles to wait for tx_valid in the read-data phase before aborting; minimum 1.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
SS_n  in  1  slave select, active low, synchronous to clk.
MOSI  in  1  serial data in, MSB first.
MISO  out  1  serial data out, MSB first; 0 when not transmitting.
rx_data  out  DATA_W+2  received frame; [DATA_W+1:DATA_W] = command, [DATA_W-1:0] = payload.
rx_valid  out  1  rx_data valid; held until rx_ready.
rx_ready  in  1  downstream accepts rx_data.
tx_data  in  DATA_W  read data from memory.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  one-cycle pulse; slave accepts tx_data.
frame_err  out  1  one-cycle pulse; frame aborted by SS_n or read timeout.
overrun  out  1  one-cycle pulse; completed frame dropped because rx_valid was still pending.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - MISO, rx_valid, tx_ready, frame_err, overrun = 0.
  - rx_data = 0.
  - addr_seen = 0; bit counter = 0; timeout counter = 0.
  - Reset mid-frame abandons the frame silently; no frame_err.
- Command codes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: samples the direction bit on MOSI.
  - 0 -> WRITE.
  - 1 and !addr_seen -> READ_ADD.
  - 1 and addr_seen -> READ_DATA.
  - Loads bit counter = FRAME_W.
- WRITE / READ_ADD / READ_DATA shift phase:
  - Shift MOSI into the shift register each cycle, MSB first, decrementing the counter.
  - The first shifted bit is the command MSB; the direction bit is not part of the frame.
  - When the counter reaches 0, the next cycle transfers the shift register to rx_data and asserts rx_valid.
  - Latency: rx_valid is visible FRAME_W+2 cycles after the IDLE->CHK_CMD edge.
  - If rx_valid is still 1 at that transfer: keep the old rx_data, drop the new frame, pulse overrun.
- READ_ADD: addr_seen <= 1 when the frame transfers or overruns.
- rx handshake:
  - rx_valid && rx_ready clears rx_valid the next cycle.
  - rx_valid is independent of SS_n and state.
- WRITE / READ_ADD after the frame: go to FRAME_END; ignore MOSI until SS_n=1.
- READ_DATA after the frame: go to TX_WAIT.
  - The timeout counter counts cycles with tx_valid=0.
  - tx_valid=1: pulse tx_ready the same cycle, latch tx_data, clear addr_seen, go to TX_SHIFT.
  - Timeout reaches TX_TIMEOUT: pulse frame_err, go to FRAME_END; addr_seen retained.
- TX_SHIFT:
  - MISO = tx_data[DATA_W-1] in the cycle after the latch, then one bit per cycle down to bit 0.
  - Then MISO=0 -> FRAME_END.
  - Total DATA_W cycles.
- FRAME_END: SS_n=1 -> IDLE.
- SS_n=1 sampled in CHK_CMD, shift, TX_WAIT or TX_SHIFT:
  - Next state IDLE; MISO <= 0; partial shift register discarded; pulse frame_err.
  - Already pending rx_valid is unaffected.
- Simultaneous events:
  - SS_n=1 in the same cycle as frame completion: the frame completes (no frame_err).
  - tx_valid with SS_n=1: abort wins; no tx_ready.
- Write-path no back-pressure: if rx_ready is held 0, later frames overrun; the slave never stalls the SPI side.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, FRAME_END).
  - cmd_e with the four codes.
  - function frame_w(DATA_W).
- Sub-module spi_tx_serializer (DATA_W): load/shift/busy, drives MISO.
- The FSM, rx shift register, handshakes and error logic stay in spi_slave_param.

Test Plan:
- Reset mid-WRITE after 4 bits -> next cycle all outputs 0, state IDLE, no frame_err.
- DATA_W=8, SS_n falls, MOSI 0 then 00_1010_0101, rx_ready=1 -> rx_data=10'h0A5, one-cycle rx_valid 12 cycles after the IDLE exit edge, no errors.
- RD_ADDR frame 10_0011_0011, then RD_DATA frame 11_xxxxxxxx, tx_data=8'hC3 with tx_valid after 3 cycles:
  - rx_data=10'h233 then 10'h3xx.
  - tx_ready pulses once.
  - MISO sequence 1,1,0,0,0,0,1,1.
  - addr_seen cleared.
- RD_DATA with tx_valid never asserted, TX_TIMEOUT=16 -> frame_err pulse 16 cycles into TX_WAIT, MISO stays 0, no tx_ready.
- Two WR frames with rx_ready=0 throughout -> rx_data holds the first frame, overrun pulses once at the second completion.
- SS_n raised after 5 payload bits -> frame_err pulse, IDLE next cycle, rx_valid stays 0.
